// File: rtl/dmem_responder.sv
// Data-memory responder: word-addressed storage with CPU store port, priority
// loader port, and a registered read path behind a configurable wait-state FSM.
module dmem_responder #(
  parameter  int DEPTH_WORDS  = 1024,
  parameter  int WAIT_STATES  = 0,
  parameter  int ADDRESS_SIZE = 32,
  parameter  int DATA_SIZE    = 32,
  localparam int IDX_W        = $clog2(DEPTH_WORDS)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ADDRESS_SIZE-1:0] dm_read_address,
  input  logic                    dm_write_enable,
  input  logic [ADDRESS_SIZE-1:0] dm_write_address,
  input  logic [DATA_SIZE-1:0]    dm_write_data,
  input  logic                    ld_write_enable,
  input  logic [IDX_W-1:0]        ld_address,
  input  logic [DATA_SIZE-1:0]    ld_data,
  output logic [DATA_SIZE-1:0]    dm_read_data,
  output logic                    dm_read_valid,
  output logic                    dm_busy,
  output logic                    dm_addr_error,
  output logic                    dm_write_conflict
);

  typedef enum logic {IDLE, COUNT} state_t;

  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  logic [DATA_SIZE-1:0]    mem [DEPTH_WORDS];
  state_t                  state;
  logic [3:0]              cnt;
  logic [ADDRESS_SIZE-1:0] served_addr;
  logic                    served_ok;
  logic [ADDRESS_SIZE-1:0] pend_addr;

  logic [IDX_W-1:0]     rd_idx, wr_idx, served_idx;
  logic                 rd_oor, wr_oor, served_oor;
  logic                 cpu_commit, hit_served, stale;
  logic [DATA_SIZE-1:0] capture_data;

  // Byte lanes [1:0] of the store address carry no meaning for word accesses.
  logic unused_wr_lanes;
  assign unused_wr_lanes = &{1'b0, dm_write_address[1:0]};

  assign rd_idx     = dm_read_address[IDX_W+1:2];
  assign wr_idx     = dm_write_address[IDX_W+1:2];
  assign served_idx = served_addr[IDX_W+1:2];
  assign rd_oor     = |dm_read_address[ADDRESS_SIZE-1:IDX_W+2];
  assign wr_oor     = |dm_write_address[ADDRESS_SIZE-1:IDX_W+2];
  assign served_oor = |served_addr[ADDRESS_SIZE-1:IDX_W+2];

  // The loader always wins; a simultaneous CPU store is dropped entirely.
  assign cpu_commit = dm_write_enable & ~ld_write_enable & ~wr_oor;

  assign hit_served = ~served_oor &
                      ((ld_write_enable & (ld_address == served_idx)) |
                       (cpu_commit & (wr_idx == served_idx)));

  assign stale = ~served_ok | (dm_read_address != served_addr) | hit_served;

  // Write-first capture: a write landing on the captured word at this edge
  // is forwarded so the read never returns the pre-write value.
  always_comb begin
    capture_data = '0;
    if (!rd_oor) begin
      if (ld_write_enable && ld_address == rd_idx)
        capture_data = ld_data;
      else if (cpu_commit && wr_idx == rd_idx)
        capture_data = dm_write_data;
      else
        capture_data = mem[rd_idx];
    end
  end

  always_ff @(posedge clock) begin
    if (ld_write_enable)
      mem[ld_address] <= ld_data;
    else if (cpu_commit)
      mem[wr_idx] <= dm_write_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= IDLE;
      cnt               <= 4'd0;
      served_addr       <= '0;
      served_ok         <= 1'b0;
      pend_addr         <= '0;
      dm_read_data      <= '0;
      dm_read_valid     <= 1'b0;
      dm_busy           <= 1'b0;
      dm_addr_error     <= 1'b0;
      dm_write_conflict <= 1'b0;
    end else begin
      if (rd_oor || (dm_write_enable && wr_oor))
        dm_addr_error <= 1'b1;
      if (dm_write_enable && ld_write_enable)
        dm_write_conflict <= 1'b1;

      case (state)
        IDLE: begin
          if (stale) begin
            if (WAIT_STATES == 0) begin
              dm_read_data  <= capture_data;
              dm_read_valid <= 1'b1;
              served_addr   <= dm_read_address;
              served_ok     <= 1'b1;
            end else begin
              dm_read_valid <= 1'b0;
              served_ok     <= 1'b0;
              cnt           <= CNT_INIT;
              pend_addr     <= dm_read_address;
              dm_busy       <= 1'b1;
              state         <= COUNT;
            end
          end
        end
        COUNT: begin
          if (dm_read_address != pend_addr) begin
            cnt       <= CNT_INIT;
            pend_addr <= dm_read_address;
          end else if (cnt == 4'd0) begin
            dm_read_data  <= capture_data;
            dm_read_valid <= 1'b1;
            served_addr   <= dm_read_address;
            served_ok     <= 1'b1;
            dm_busy       <= 1'b0;
            state         <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances (0, 3 and 2 wait states)
// share one stimulus stream; each scenario checks the instance it targets.
module tb_dmem_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] dm_read_address;
  logic        dm_write_enable;
  logic [31:0] dm_write_address;
  logic [31:0] dm_write_data;
  logic        ld_write_enable;
  logic [9:0]  ld_address;
  logic [31:0] ld_data;

  logic [31:0] data0, data3, data2;
  logic        valid0, valid3, valid2;
  logic        busy0, busy3, busy2;
  logic        aerr0, aerr3, aerr2;
  logic        conf0, conf3, conf2;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut0 (
    .clock(clock), .reset(reset),
    .dm_read_address(dm_read_address), .dm_write_enable(dm_write_enable),
    .dm_write_address(dm_write_address), .dm_write_data(dm_write_data),
    .ld_write_enable(ld_write_enable), .ld_address(ld_address), .ld_data(ld_data),
    .dm_read_data(data0), .dm_read_valid(valid0), .dm_busy(busy0),
    .dm_addr_error(aerr0), .dm_write_conflict(conf0));

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) dut3 (
    .clock(clock), .reset(reset),
    .dm_read_address(dm_read_address), .dm_write_enable(dm_write_enable),
    .dm_write_address(dm_write_address), .dm_write_data(dm_write_data),
    .ld_write_enable(ld_write_enable), .ld_address(ld_address), .ld_data(ld_data),
    .dm_read_data(data3), .dm_read_valid(valid3), .dm_busy(busy3),
    .dm_addr_error(aerr3), .dm_write_conflict(conf3));

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) dut2 (
    .clock(clock), .reset(reset),
    .dm_read_address(dm_read_address), .dm_write_enable(dm_write_enable),
    .dm_write_address(dm_write_address), .dm_write_data(dm_write_data),
    .ld_write_enable(ld_write_enable), .ld_address(ld_address), .ld_data(ld_data),
    .dm_read_data(data2), .dm_read_valid(valid2), .dm_busy(busy2),
    .dm_addr_error(aerr2), .dm_write_conflict(conf2));

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [9:0] idx, input logic [31:0] data);
    ld_write_enable = 1'b1;
    ld_address      = idx;
    ld_data         = data;
    tick();
    ld_write_enable = 1'b0;
  endtask

  initial begin
    reset            = 1'b1;
    dm_read_address  = 32'h0;
    dm_write_enable  = 1'b0;
    dm_write_address = 32'h0;
    dm_write_data    = 32'h0;
    ld_write_enable  = 1'b0;
    ld_address       = 10'd0;
    ld_data          = 32'h0;
    tick();
    tick();
    checkOutput("rst_data",     data0,  32'h0);
    checkOutput("rst_valid",    {31'd0, valid0}, 32'd0);
    checkOutput("rst_busy",     {31'd0, busy3},  32'd0);
    checkOutput("rst_aerr",     {31'd0, aerr0},  32'd0);
    checkOutput("rst_conflict", {31'd0, conf0},  32'd0);
    reset = 1'b0;

    applyStimulus(10'd4, 32'hDEADBEEF);
    applyStimulus(10'd5, 32'h00000005);
    applyStimulus(10'd8, 32'h00000000);
    applyStimulus(10'd9, 32'h99999999);
    applyStimulus(10'd1, 32'h01010101);
    tick();

    // Preload read, zero wait states
    dm_read_address = 32'h10;
    tick();
    checkOutput("ws0_data",  data0, 32'hDEADBEEF);
    checkOutput("ws0_valid", {31'd0, valid0}, 32'd1);
    checkOutput("ws3_busy_first", {31'd0, busy3}, 32'd1);
    tick(); tick(); tick();
    checkOutput("ws3_first_data", data3, 32'hDEADBEEF);

    // Wait-state window on an address change
    dm_read_address = 32'h14;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checkOutput($sformatf("ws3_busy_t%0d", k),  {31'd0, busy3},  32'd1);
      checkOutput($sformatf("ws3_valid_t%0d", k), {31'd0, valid3}, 32'd0);
    end
    tick();
    checkOutput("ws3_valid_t4", {31'd0, valid3}, 32'd1);
    checkOutput("ws3_data_t4",  data3, 32'h5);
    checkOutput("ws3_busy_t4",  {31'd0, busy3}, 32'd0);

    // Coherence on the served address
    dm_read_address = 32'h20;
    tick(); tick(); tick(); tick();
    checkOutput("coh_pre_ws0", data0, 32'h0);
    dm_write_enable  = 1'b1;
    dm_write_address = 32'h20;
    dm_write_data    = 32'h12345678;
    tick();
    dm_write_enable = 1'b0;
    checkOutput("coh_ws0_data",  data0, 32'h12345678);
    checkOutput("coh_ws0_valid", {31'd0, valid0}, 32'd1);
    checkOutput("coh_ws2_drop1", {31'd0, valid2}, 32'd0);
    tick();
    checkOutput("coh_ws0_valid2", {31'd0, valid0}, 32'd1);
    checkOutput("coh_ws2_drop2",  {31'd0, valid2}, 32'd0);
    tick();
    checkOutput("coh_ws2_valid", {31'd0, valid2}, 32'd1);
    checkOutput("coh_ws2_data",  data2, 32'h12345678);

    // Loader/CPU collision: loader to index 8, CPU store to 0x24 dropped
    ld_write_enable  = 1'b1;
    ld_address       = 10'd8;
    ld_data          = 32'hAAAA0000;
    dm_write_enable  = 1'b1;
    dm_write_address = 32'h24;
    dm_write_data    = 32'h55;
    tick();
    ld_write_enable = 1'b0;
    dm_write_enable = 1'b0;
    checkOutput("col_conflict", {31'd0, conf0}, 32'd1);
    checkOutput("col_idx8",     data0, 32'hAAAA0000);
    dm_read_address = 32'h24;
    tick();
    checkOutput("col_idx9", data0, 32'h99999999);
    tick(); tick();
    checkOutput("col_sticky", {31'd0, conf0}, 32'd1);

    // Out-of-range read and store
    checkOutput("oor_aerr_pre", {31'd0, aerr0}, 32'd0);
    dm_read_address = 32'h1000;
    tick();
    checkOutput("oor_data", data0, 32'h0);
    checkOutput("oor_aerr", {31'd0, aerr0}, 32'd1);
    dm_write_enable  = 1'b1;
    dm_write_address = 32'h1004;
    dm_write_data    = 32'hFFFFFFFF;
    tick();
    dm_write_enable = 1'b0;
    dm_read_address = 32'h4;
    tick();
    checkOutput("oor_no_alias", data0, 32'h01010101);

    // Address churn during wait states
    tick(); tick(); tick(); tick();
    for (int i = 0; i < 5; i++) begin
      dm_read_address = (i % 2 == 0) ? 32'h14 : 32'h10;
      tick();
      checkOutput($sformatf("churn_valid_%0d", i), {31'd0, valid3}, 32'd0);
    end
    tick();
    checkOutput("settle_s2", {31'd0, valid3}, 32'd0);
    tick();
    checkOutput("settle_s3", {31'd0, valid3}, 32'd0);
    tick();
    checkOutput("settle_s4_valid", {31'd0, valid3}, 32'd1);
    checkOutput("settle_s4_data",  data3, 32'h5);

    // Reset during COUNT
    dm_read_address = 32'h10;
    tick();
    checkOutput("midrst_busy_pre", {31'd0, busy3}, 32'd1);
    reset = 1'b1;
    tick();
    checkOutput("midrst_busy",  {31'd0, busy3},  32'd0);
    checkOutput("midrst_valid", {31'd0, valid3}, 32'd0);
    checkOutput("midrst_data",  data3, 32'h0);
    checkOutput("midrst_aerr",  {31'd0, aerr3},  32'd0);
    checkOutput("midrst_conf",  {31'd0, conf3},  32'd0);
    reset = 1'b0;
    tick();
    checkOutput("postrst_ws0_data", data0, 32'hDEADBEEF);
    checkOutput("postrst_ws3_busy", {31'd0, busy3}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the five-stage pipeline: the memory-side end of the CPU's `dm_*` port. It holds a word-addressed storage array, commits CPU stores, and returns load data through a registered read path with a configurable wait-state FSM, so the MEM stage can be exercised against non-ideal memory latency. A side loader port preloads or patches memory from the testbench or boot logic and has priority over CPU stores. Sits at the `cpu` top level beside the instruction memory.

## Interface
- `DEPTH_WORDS`, 1024: number of 32-bit words; word index width `IDX_W = $clog2(DEPTH_WORDS)`.
- `WAIT_STATES`, 0: extra cycles, 0–15, inserted before each new read result.
- `clock` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `dm_read_address` input `ADDRESS_SIZE`: byte address of the load; bits [1:0] are ignored.
- `dm_write_enable` input 1: CPU store strobe, one word per cycle.
- `dm_write_address` input `ADDRESS_SIZE`: byte address of the store; bits [1:0] are ignored.
- `dm_write_data` input `DATA_SIZE`: store data.
- `ld_write_enable` input 1: loader write strobe.
- `ld_address` input `IDX_W`: loader word index.
- `ld_data` input `DATA_SIZE`: loader write data.
- `dm_read_data` output `DATA_SIZE`: registered load data.
- `dm_read_valid` output 1: `dm_read_data` is the current contents of the address on `dm_read_address`.
- `dm_busy` output 1: a read is in wait states (FSM in COUNT).
- `dm_addr_error` output 1: sticky flag; set by any out-of-range read or write.
- `dm_write_conflict` output 1: sticky flag; set when a CPU store is dropped because of a loader write.

## Operation
- **Word index:** the index is `addr[IDX_W+1:2]`. An access is out of range if `addr[ADDRESS_SIZE-1:IDX_W+2]` is nonzero.
- **Out-of-range accesses:** such a write is dropped. Such a read returns 0. Both set `dm_addr_error`.
- **Writes:**
  - A write commits at the clock edge where it is sampled.
  - If `ld_write_enable` and `dm_write_enable` are high in the same cycle, only the loader write commits. The CPU store is dropped and `dm_write_conflict` is set, even if the two addresses differ.
- **Read tracking:** `served_addr` and `served_ok` record the address whose data is held in `dm_read_data`. A read is *stale* when any of these holds:
  - `served_ok` is 0,
  - `dm_read_address` differs from `served_addr`,
  - a committed write (loader or CPU) targets `served_addr`.
- **FSM states:** IDLE and COUNT, with down-counter `cnt` (4 bits).
  - **IDLE, read not stale:** hold all outputs.
  - **IDLE, read stale, `WAIT_STATES` = 0:** capture at this edge. Set `dm_read_data` to `mem[idx]`, set `dm_read_valid` to 1, set `served_addr` to the current address, set `served_ok` to 1.
  - **IDLE, read stale, `WAIT_STATES` > 0:** set `dm_read_valid` to 0, set `cnt` to `WAIT_STATES-1`, go to COUNT.
  - **COUNT, address changed since entry:** restart with `cnt` = `WAIT_STATES-1`. `dm_read_valid` stays 0.
  - **COUNT, `cnt` = 0:** capture as above, then go to IDLE.
  - **COUNT, otherwise:** decrement `cnt`.
- **Capture forwarding:** capture is write-first. If a committed write targets the captured index at the same edge, `dm_read_data` takes the write data.
- **Array reset:** memory contents are not reset.

## Timing
- **Reset values:**
  - `dm_read_data` = 0, `dm_read_valid` = 0, `dm_busy` = 0.
  - `dm_addr_error` = 0, `dm_write_conflict` = 0.
  - FSM in IDLE, `served_ok` = 0, `cnt` = 0.
- **Reset mid-read:** reset during COUNT abandons the read. The first cycle after reset is a stale read.
- **Read latency:** address A is presented in cycle t with A stable. `dm_read_valid` = 1 with `mem[A]` in cycle t+1+`WAIT_STATES`.
- **Busy window:** `dm_busy` is high in cycles t+1 … t+`WAIT_STATES`.
- **Store-then-load:**
  - A store in cycle t makes the new value readable at a different address in cycle t+1+`WAIT_STATES`.
  - For the served address itself, `dm_read_valid` drops in t+1 when `WAIT_STATES` > 0. When `WAIT_STATES` = 0 it stays 1 and the data updates in t+1.
- **Write throughput:** one write per cycle, with no backpressure on writes.
- **Sticky flags:** both flags rise in the cycle after the triggering edge and clear only on reset.

## Test plan
- **Reset, then preload:** loader writes `0xDEADBEEF` at index 4. CPU reads byte address `0x10` with `WAIT_STATES`=0 → `dm_read_data`=`0xDEADBEEF` and `dm_read_valid`=1 one cycle after the address is applied.
- **Wait states:** `WAIT_STATES`=3. Change the read address from `0x10` to `0x14` (contents `0x00000005`) in cycle t → `dm_busy` high in t+1..t+3, `dm_read_valid` low in t+1..t+3, data `0x5` valid in t+4.
- **Coherence:** with `WAIT_STATES`=0 and the read held at `0x20`, the CPU stores `0x12345678` to `0x20` → `dm_read_data`=`0x12345678` the next cycle and `dm_read_valid` never drops. With `WAIT_STATES`=2 → valid drops for 2 cycles, then the new data appears.
- **Loader/CPU collision:** loader writes `0xAAAA0000` to index 8 while the CPU stores `0x55` to `0x24` in the same cycle → index 8 = `0xAAAA0000`, index 9 unchanged, `dm_write_conflict`=1 until reset.
- **Out of range:** with `DEPTH_WORDS`=1024, read `0x00001000` → `dm_read_data`=0 and `dm_addr_error`=1. A store to `0x00001004` leaves the array unchanged.
- **Mid-read changes:**
  - With `WAIT_STATES`=3, change the address every cycle for 5 cycles → `dm_read_valid` stays 0. After the address stabilizes, valid appears 4 cycles later.
  - Assert reset during COUNT → all outputs return to reset values the next cycle.
